// File: rtl/lcd_responder.sv
// lcd_responder: behavioural responder for an HD44780-style character LCD.
// Accepts 8-bit or 4-bit transfers on LCD_E falling edges, executes instructions
// and data writes into a 128-byte DDRAM, and answers status/data reads.
// Optional build macro: LCD_RESP_LINE_WRAP_EN (two-line address wrap for AC stepping).
//
// Ports:
//   CLK, RESET            clock (rising edge), asynchronous active-high reset
//   LCD_E, LCD_RS, LCD_RW controller strobe, register select, read/write
//   LCD_D                 4-bit bidirectional bus (controller D7..D4)
//   dbg_addr, dbg_data    DDRAM debug read port, 1-cycle latency
//   busy                  busy flag (BF)
//   four_bit_mode         set once Function Set with DL=0 has executed
//   display_on            D bit of Display Control
//   err_wr_busy           sticky: a write arrived while busy
module lcd_responder #(
    parameter int unsigned BUSY_CYCLES  = 50,
    parameter int unsigned CLEAR_CYCLES = 2000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    inout  wire  [3:0] LCD_D,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       busy,
    output logic       four_bit_mode,
    output logic       display_on,
    output logic       err_wr_busy
);

    localparam int unsigned CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned DEPTH   = 128;

    typedef enum logic [1:0] {ST_READY, ST_BUSY, ST_FILL} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         fill_q, fill_d;
    logic               busy_d;

    logic               e_q, rs_l, rw_l;
    logic [3:0]         d_l, hi_q;
    logic               phase_q;        // 1 = low nibble expected next
    logic [6:0]         ac_q;
    logic               id_q;
    logic [7:0]         ddram [DEPTH];

    logic               fall, xfer, exec_wr, clear_wr, data_wr, data_rd;
    logic [7:0]         wr_byte, rd_byte, mem_wdata;
    logic [6:0]         mem_addr;
    logic               mem_we, drive;
    logic [3:0]         rd_nib;

    // AC step, optionally jumping between the two 40-character display lines
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
        logic [6:0] r;
`ifdef LCD_RESP_LINE_WRAP_EN
        if (up) r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        else    r = (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : a - 7'd1;
`else
        r = up ? a + 7'd1 : a - 7'd1;
`endif
        return r;
    endfunction

    // Transfer decode: a transfer completes on every fall in 8-bit mode, on the low nibble in 4-bit mode
    assign fall     = e_q & ~LCD_E;
    assign xfer     = fall & (~four_bit_mode | phase_q);
    assign wr_byte  = four_bit_mode ? {hi_q, d_l} : {d_l, 4'b0000};
    assign exec_wr  = xfer & ~rw_l & ~busy;
    assign clear_wr = exec_wr & ~rs_l & (wr_byte == 8'h01);
    assign data_wr  = exec_wr & rs_l;
    assign data_rd  = xfer & rw_l & rs_l;

    // Busy/fill sequencer: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        busy_d  = busy;
        unique case (state_q)
            ST_READY: begin
                if (exec_wr) begin
                    busy_d = 1'b1;
                    if (clear_wr) begin
                        state_d = ST_FILL;
                        cnt_d   = CNT_W'(CLEAR_CYCLES);
                        fill_d  = 7'd0;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(BUSY_CYCLES);
                    end
                end
            end
            ST_FILL: begin
                fill_d = fill_q + 7'd1;
                cnt_d  = cnt_q - CNT_W'(1);
                if (fill_q == 7'h7F) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_READY;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    // Busy/fill sequencer: state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_READY;
            cnt_q   <= '0;
            fill_q  <= 7'd0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            busy    <= busy_d;
        end
    end

    // Bus capture, nibble phase, AC/ID and mode registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            e_q           <= 1'b0;
            rs_l          <= 1'b0;
            rw_l          <= 1'b0;
            d_l           <= 4'd0;
            hi_q          <= 4'd0;
            phase_q       <= 1'b0;
            ac_q          <= 7'd0;
            id_q          <= 1'b1;
            four_bit_mode <= 1'b0;
            display_on    <= 1'b0;
            err_wr_busy   <= 1'b0;
            dbg_data      <= 8'h00;
        end else begin
            e_q      <= LCD_E;
            dbg_data <= ddram[dbg_addr];
            if (LCD_E) begin
                rs_l <= LCD_RS;
                rw_l <= LCD_RW;
                d_l  <= LCD_D;
            end
            if (fall && four_bit_mode) begin
                phase_q <= ~phase_q;
                if (!phase_q) hi_q <= d_l;
            end
            if (xfer && !rw_l && busy) err_wr_busy <= 1'b1;
            if (data_wr || data_rd) ac_q <= ac_step(ac_q, id_q);
            // Instruction decode, highest set bit wins; Function Set overrides the phase toggle
            if (exec_wr && !rs_l) begin
                if (wr_byte[7]) begin
                    ac_q <= wr_byte[6:0];
                end else if (wr_byte[6]) begin
                    // CGRAM address: accepted, no CGRAM modelled
                end else if (wr_byte[5]) begin
                    four_bit_mode <= ~wr_byte[4];
                    phase_q       <= 1'b0;
                end else if (wr_byte[4]) begin
                    if (!wr_byte[3]) ac_q <= ac_step(ac_q, wr_byte[2]);
                end else if (wr_byte[3]) begin
                    display_on <= wr_byte[2];
                end else if (wr_byte[2]) begin
                    id_q <= wr_byte[1];
                end else if (wr_byte[1]) begin
                    ac_q <= 7'd0;
                end else if (wr_byte[0]) begin
                    ac_q <= 7'd0;
                    id_q <= 1'b1;
                end
            end
        end
    end

    // DDRAM write port: clear fill has the port while active, otherwise data writes
    assign mem_we    = (state_q == ST_FILL) | data_wr;
    assign mem_addr  = (state_q == ST_FILL) ? fill_q : ac_q;
    assign mem_wdata = (state_q == ST_FILL) ? 8'h20 : wr_byte;

    // DDRAM storage, deliberately not reset
    always_ff @(posedge CLK) begin
        if (mem_we) ddram[mem_addr] <= mem_wdata;
    end

    // Read return: nibble chosen by phase; 8-bit mode only ever returns the high nibble
    assign rd_byte = LCD_RS ? ddram[ac_q] : {busy, ac_q};
    assign rd_nib  = (four_bit_mode && phase_q) ? rd_byte[3:0] : rd_byte[7:4];
    assign drive   = LCD_E & LCD_RW & ~RESET;
    assign LCD_D   = drive ? rd_nib : 4'bzzzz;

endmodule

// File: tb/tb_lcd_responder.sv
// tb_lcd_responder: directed bench for lcd_responder. Stimulus pushes expected
// values into a scoreboard queue; a negedge monitor pops and compares them.
module tb_lcd_responder;

    localparam int K_BUSY = 0;
    localparam int K_4BIT = 1;
    localparam int K_DISP = 2;
    localparam int K_ERR  = 3;
    localparam int K_DBG  = 4;
    localparam int K_LCD  = 5;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       LCD_E, LCD_RS, LCD_RW;
    wire  [3:0] LCD_D;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_data;
    logic       busy, four_bit_mode, display_on, err_wr_busy;

    logic       tb_drv;
    logic [3:0] tb_d;

    assign LCD_D = tb_drv ? tb_d : 4'bzzzz;
    pullup pu_lcd (LCD_D);   // a released bus reads back as 4'hF

    lcd_responder dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .LCD_E         (LCD_E),
        .LCD_RS        (LCD_RS),
        .LCD_RW        (LCD_RW),
        .LCD_D         (LCD_D),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data),
        .busy          (busy),
        .four_bit_mode (four_bit_mode),
        .display_on    (display_on),
        .err_wr_busy   (err_wr_busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         kind;
        logic [7:0] exp;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    task automatic expect_val(input int kind, input logic [7:0] v, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        sb.push_back(e);
        sb_name.push_back(name);
    endtask

    function automatic logic [7:0] observe(input int kind);
        case (kind)
            K_BUSY:  return {7'd0, busy};
            K_4BIT:  return {7'd0, four_bit_mode};
            K_DISP:  return {7'd0, display_on};
            K_ERR:   return {7'd0, err_wr_busy};
            K_DBG:   return dbg_data;
            K_LCD:   return {4'd0, LCD_D};
            default: return 8'h00;
        endcase
    endfunction

    // Monitor: drain the scoreboard at each falling edge
    exp_t       m_e;
    string      m_nm;
    logic [7:0] m_obs;
    always @(negedge CLK) begin
        while (sb.size() != 0) begin
            m_e   = sb.pop_front();
            m_nm  = sb_name.pop_front();
            m_obs = observe(m_e.kind);
            n_vec++;
            if (m_obs !== m_e.exp) begin
                n_fail++;
                $display("FAIL %s: got %02h expected %02h", m_nm, m_obs, m_e.exp);
            end
        end
    end

    task automatic wr_nib(input logic rs, input logic [3:0] n);
        @(posedge CLK); #1;
        LCD_RS = rs; LCD_RW = 1'b0; tb_d = n; tb_drv = 1'b1; LCD_E = 1'b1;
        repeat (2) @(posedge CLK);
        #1 LCD_E = 1'b0;
        @(posedge CLK); #1;
        tb_drv = 1'b0;
    endtask

    task automatic wr_byte(input logic rs, input logic [7:0] b);
        wr_nib(rs, b[7:4]);
        wr_nib(rs, b[3:0]);
    endtask

    task automatic rd_nib(input logic rs, input logic [3:0] exp, input string name);
        @(posedge CLK); #1;
        LCD_RS = rs; LCD_RW = 1'b1; tb_drv = 1'b0; LCD_E = 1'b1;
        @(posedge CLK); #1;
        expect_val(K_LCD, {4'd0, exp}, name);
        @(posedge CLK); #1;
        LCD_E = 1'b0;
        @(posedge CLK); #1;
        LCD_RW = 1'b0;
        expect_val(K_LCD, 8'h0F, {name, "_released"});
    endtask

    task automatic status_rd(input logic [7:0] exp, input string name);
        rd_nib(1'b0, exp[7:4], {name, "_hi"});
        rd_nib(1'b0, exp[3:0], {name, "_lo"});
    endtask

    task automatic wait_ready(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            @(posedge CLK); #1;
            k++;
        end
        if (busy) begin
            n_vec++;
            n_fail++;
            $display("FAIL wait_ready: busy still 1 after %0d cycles", budget);
        end
    endtask

    // Called right after the executing fall: busy high for exactly n cycles
    task automatic busy_dur(input int n, input string name);
        repeat (n - 1) @(posedge CLK);
        #1 expect_val(K_BUSY, 8'h01, {name, "_last"});
        @(posedge CLK); #1;
        expect_val(K_BUSY, 8'h00, {name, "_clear"});
    endtask

    task automatic dbg_chk(input logic [6:0] a, input logic [7:0] exp, input string name);
        dbg_addr = a;
        @(posedge CLK); #1;
        expect_val(K_DBG, exp, name);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, busy=%0d", busy);
        $fatal(1, "watchdog");
    end

    logic [3:0] init_seq [4];

    initial begin
        RESET = 1'b1; LCD_E = 1'b0; LCD_RS = 1'b0; LCD_RW = 1'b0;
        tb_drv = 1'b0; tb_d = 4'd0; dbg_addr = 7'd0;
        init_seq[0] = 4'h3; init_seq[1] = 4'h3; init_seq[2] = 4'h3; init_seq[3] = 4'h2;

        // Reset state, with a read strobe applied so the bus must stay released
        repeat (3) @(posedge CLK);
        #1 LCD_E = 1'b1; LCD_RW = 1'b1;
        expect_val(K_BUSY, 8'h00, "rst_busy");
        expect_val(K_4BIT, 8'h00, "rst_4bit");
        expect_val(K_DISP, 8'h00, "rst_disp");
        expect_val(K_ERR,  8'h00, "rst_err");
        expect_val(K_DBG,  8'h00, "rst_dbg");
        expect_val(K_LCD,  8'h0F, "rst_bus_released");
        @(posedge CLK); #1;
        LCD_E = 1'b0; LCD_RW = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;

        // Init sequence in 8-bit mode
        for (int i = 0; i < 4; i++) begin
            wr_nib(1'b0, init_seq[i]);
            expect_val(K_BUSY, 8'h01, "init_busy_set");
            if (i == 0 || i == 3) busy_dur(50, "init_busy");
            wait_ready(3000);
            if (i == 2) expect_val(K_4BIT, 8'h00, "init_still_8bit");
        end
        expect_val(K_4BIT, 8'h01, "init_4bit");

        // 4-bit writes, debug readback, status read
        wr_byte(1'b0, 8'h80); wait_ready(3000);
        wr_byte(1'b1, 8'h41); wait_ready(3000);
        wr_byte(1'b1, 8'h42); wait_ready(3000);
        dbg_chk(7'd0, 8'h41, "ddram0");
        dbg_chk(7'd1, 8'h42, "ddram1");
        status_rd(8'h02, "status_ac2");
        wr_byte(1'b0, 8'h0C); wait_ready(3000);
        expect_val(K_DISP, 8'h01, "display_on");

        // Data read returns DDRAM[AC] and steps AC
        wr_byte(1'b0, 8'h80); wait_ready(3000);
        rd_nib(1'b1, 4'h4, "data_rd_hi");
        rd_nib(1'b1, 4'h1, "data_rd_lo");
        status_rd(8'h01, "status_after_rd");

        // Write while busy is discarded and latches the error flag
        wr_byte(1'b0, 8'h85); wait_ready(3000);
        wr_byte(1'b1, 8'h33);
        repeat (10) @(posedge CLK);
        #1 wr_byte(1'b1, 8'h77);
        expect_val(K_ERR, 8'h01, "err_wr_busy");
        wait_ready(3000);
        dbg_chk(7'h05, 8'h33, "ddram5_kept");
        status_rd(8'h06, "status_discard");

        // AC stepping across the line boundary
        wr_byte(1'b0, 8'hA7); wait_ready(3000);
        wr_byte(1'b1, 8'h5A); wait_ready(3000);
`ifdef LCD_RESP_LINE_WRAP_EN
        status_rd(8'h40, "status_wrap_up");
`else
        status_rd(8'h28, "status_wrap_up");
`endif
        dbg_chk(7'h27, 8'h5A, "ddram27");

        // Decrement below 0, then cursor shift right back to 0
        wr_byte(1'b0, 8'h04); wait_ready(3000);
        wr_byte(1'b0, 8'h80); wait_ready(3000);
        wr_byte(1'b1, 8'h11); wait_ready(3000);
`ifdef LCD_RESP_LINE_WRAP_EN
        status_rd(8'h67, "status_wrap_down");
`else
        status_rd(8'h7F, "status_wrap_down");
`endif
        wr_byte(1'b0, 8'h14); wait_ready(3000);
        status_rd(8'h00, "status_shift_up");
        wr_byte(1'b0, 8'h06); wait_ready(3000);

        // Clear Display fills DDRAM with spaces
        wr_byte(1'b0, 8'hFF); wait_ready(3000);
        wr_byte(1'b1, 8'h99); wait_ready(3000);
        wr_byte(1'b0, 8'hD0); wait_ready(3000);
        wr_byte(1'b1, 8'h64); wait_ready(3000);
        dbg_chk(7'h7F, 8'h99, "ddram7f_pre");
        dbg_chk(7'h50, 8'h64, "ddram50_pre");
        wr_byte(1'b0, 8'h01);
        busy_dur(2000, "clear_busy");
        for (int a = 0; a < 128; a++) dbg_chk(7'(a), 8'h20, "clear_fill");
        status_rd(8'h00, "status_after_clear");
        expect_val(K_ERR, 8'h01, "err_sticky");

        // Reset 20 cycles into a clear fill
        wr_byte(1'b0, 8'hFF); wait_ready(3000);
        wr_byte(1'b1, 8'hA5); wait_ready(3000);
        wr_byte(1'b0, 8'hD0); wait_ready(3000);
        wr_byte(1'b1, 8'h5C); wait_ready(3000);
        wr_byte(1'b0, 8'h94); wait_ready(3000);
        wr_byte(1'b1, 8'hC3); wait_ready(3000);
        wr_byte(1'b0, 8'h01);
        repeat (20) @(posedge CLK);
        #1 RESET = 1'b1; LCD_E = 1'b1; LCD_RW = 1'b1;
        expect_val(K_BUSY, 8'h00, "midfill_rst_busy");
        expect_val(K_LCD,  8'h0F, "midfill_rst_bus");
        @(posedge CLK); #1;
        LCD_E = 1'b0; LCD_RW = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
        dbg_chk(7'h14, 8'hC3, "ddram14_kept");
        dbg_chk(7'h50, 8'h5C, "ddram50_kept");
        dbg_chk(7'h7F, 8'hA5, "ddram7f_kept");
        dbg_chk(7'h13, 8'h20, "ddram13_filled");
        dbg_chk(7'h00, 8'h20, "ddram00_filled");
        expect_val(K_ERR,  8'h00, "post_rst_err");
        expect_val(K_4BIT, 8'h00, "post_rst_4bit");
        expect_val(K_DISP, 8'h00, "post_rst_disp");

        repeat (2) @(negedge CLK);
        #1 $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_responder.md
LCD_RESPONDER -- requirements
Module: lcd_responder

Interface
REQ-001 The block SHALL have parameter BUSY_CYCLES, default 50: busy duration in CLK cycles after any non-clear instruction or data write.
REQ-002 The block SHALL have parameter CLEAR_CYCLES, default 2000 (legal range 128 or more): busy duration in CLK cycles after Clear Display.
REQ-003 The block SHALL have port CLK, input, width 1: the single clock; all logic SHALL be on its rising edge.
REQ-004 The block SHALL have port RESET, input, width 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port LCD_E, input, width 1: enable strobe from the controller.
REQ-006 The block SHALL have port LCD_RS, input, width 1: 0 = instruction/status, 1 = data.
REQ-007 The block SHALL have port LCD_RW, input, width 1: 0 = write, 1 = read.
REQ-008 The block SHALL have port LCD_D, inout, width 4: data bus carrying the controller's D7..D4.
REQ-009 The block SHALL have port dbg_addr, input, width 7: DDRAM debug read address.
REQ-010 The block SHALL have port dbg_data, output, width 8: DDRAM[dbg_addr], registered with 1-cycle latency.
REQ-011 The block SHALL have port busy, output, width 1: the busy flag (BF).
REQ-012 The block SHALL have port four_bit_mode, output, width 1: 1 once Function Set with DL=0 has executed.
REQ-013 The block SHALL have port display_on, output, width 1: the D bit of Display Control.
REQ-014 The block SHALL have port err_wr_busy, output, width 1: sticky flag, set when a write arrives while busy.

Function
REQ-015 The block SHALL register LCD_E every cycle and SHALL detect a falling edge when the registered value is 1 and the current LCD_E is 0.
REQ-016 The block SHALL latch LCD_RS, LCD_RW and LCD_D every cycle in which LCD_E=1, and SHALL use those latched values at the falling edge.
REQ-017 In 8-bit mode (the state after reset), each falling edge SHALL be one complete transfer whose byte is {latched D, 4'b0000}.
REQ-018 In 4-bit mode, a nibble-phase bit SHALL toggle on every falling edge (read or write), high nibble first, and the transfer SHALL complete on the low nibble.
REQ-019 A completed write SHALL execute only if busy=0; otherwise the write SHALL be discarded and err_wr_busy SHALL be set to 1.
REQ-020 Instruction decode on the written byte b SHALL be, in priority order: b[7] sets AC=b[6:0]; b[6] (CGRAM address) is accepted with no effect; b[5] (Function Set) sets four_bit_mode=~b[4] and resets the nibble phase to high; b[4] with b[3]=0 moves AC by +1 if b[2]=1, else by -1, and with b[3]=1 has no effect; b[3] sets display_on=b[2]; b[2] sets the increment flag ID=b[1]; b[1] sets AC=0; b[0] is Clear Display.
REQ-021 A data write SHALL store the byte at DDRAM[AC] and then step AC by +1 if ID=1, or by -1 if ID=0.
REQ-022 Clear Display SHALL set AC=0 and ID=1 and SHALL write 0x20 to all 128 DDRAM locations, one location per cycle, by means of a fill counter.
REQ-023 An executed instruction or data write SHALL set busy=1 on the following cycle; busy SHALL then stay 1 for BUSY_CYCLES cycles, or CLEAR_CYCLES cycles for Clear Display, the fill being complete before busy clears.
REQ-024 A read (latched RW=1) SHALL be accepted while busy.
REQ-025 During a read, the block SHALL drive LCD_D while LCD_E=1 and LCD_RW=1, and SHALL hold LCD_D at high impedance at all other times.
REQ-026 A status read (RS=0) SHALL return {BF, AC[6:4]} on the high nibble and AC[3:0] on the low nibble; in 8-bit mode only the high nibble SHALL be returned.
REQ-027 A data read (RS=1) SHALL return the nibbles of DDRAM[AC] and SHALL step AC per ID after the low nibble, or after the single transfer in 8-bit mode.
REQ-028 AC SHALL be 7 bits wide and SHALL wrap modulo 128 (0x7F+1 gives 0x00, 0x00-1 gives 0x7F) unless the macro in REQ-032 is defined.

Reset
REQ-029 While RESET=1, the block SHALL set AC=0, ID=1, four_bit_mode=0, nibble phase=high, display_on=0, busy=0, err_wr_busy=0, dbg_data=0x00, and LCD_D to high impedance.
REQ-030 RESET SHALL NOT initialise DDRAM contents.
REQ-031 Reset asserted mid-fill or mid-nibble SHALL abort the operation immediately, with no further DDRAM writes.

Configuration
REQ-032 When LCD_RESP_LINE_WRAP_EN is defined, AC increment SHALL map 0x27 to 0x40 and 0x67 to 0x00, decrement SHALL map 0x40 to 0x27 and 0x00 to 0x67, and a Set DDRAM Address value outside 0x00-0x27 and 0x40-0x67 SHALL be taken modulo 128 unchanged; when the macro is not defined, the plain modulo-128 rule of REQ-028 SHALL apply.

Verification
REQ-033 Init sequence: writes of 0x3, 0x3, 0x3, then 0x2 in 8-bit mode, each after BF=0 -> four_bit_mode=1 after the fourth write, busy=1 for 50 cycles after each write.
REQ-034 4-bit writes: instruction 0x80, then data 0x41 and 0x42 -> dbg_addr=0 reads 0x41, dbg_addr=1 reads 0x42, and a status read returns 0x02 once busy=0.
REQ-035 Clear Display (0x01) after data writes -> busy=1 for 2000 cycles, all 128 locations read 0x20, AC=0.
REQ-036 Write issued 10 cycles after a data write -> write discarded, DDRAM unchanged, err_wr_busy=1 until reset.
REQ-037 Instruction 0xA7, then a data write -> with LCD_RESP_LINE_WRAP_EN the status read returns AC=0x40; without it, AC=0x28.
REQ-038 RESET asserted 20 cycles into a Clear Display fill -> busy=0 and LCD_D at high impedance on the next cycle, and locations 20..127 keep their prior values.
